ima_adpcm_block_packer: RTL

- Sits directly downstream of the IMA ADPCM encoder and consumes its 4-bit code stream plus its predictor/step-index state outputs.
- Packs codes into fixed-size byte blocks for the storage/transport side. Each block is a 4-byte state header followed by NIBBLES_PER_BLOCK codes, two per byte, low nibble first.
- Output bytes pass through a first-word-fall-through byte FIFO with valid/ready backpressure.

---
 rtl/ima_adpcm_block_packer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ima_adpcm_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : ima_adpcm_block_packer
// Brief    : Packs IMA ADPCM codes into state-headered byte blocks, FWFT FIFO out.
// Revision : 1.0
// ============================================================================
module ima_adpcm_block_packer #(
   parameter int NIBBLES_PER_BLOCK = 504,
   parameter int FIFO_DEPTH        = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  inPCM,
   input  logic        inValid,
   input  logic [15:0] inPredictSamp,
   input  logic [6:0]  inStepIndex,
   input  logic        flush,
   output logic        inReady,
   output logic [7:0]  outByte,
   output logic        outLast,
   output logic        outValid,
   input  logic        outReady,
   output logic        overflow
);

   localparam int C_CNT_W = $clog2(NIBBLES_PER_BLOCK + 1);
   localparam int C_PTR_W = $clog2(FIFO_DEPTH);
   localparam int C_OCC_W = C_PTR_W + 1;

   localparam logic [C_CNT_W-1:0] C_CNT_FULL  = C_CNT_W'(NIBBLES_PER_BLOCK);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
   localparam logic [C_OCC_W-1:0] C_READY_MAX = C_OCC_W'(FIFO_DEPTH - 5);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR0 = 3'd1,
      S_HDR1 = 3'd2,
      S_HDR2 = 3'd3,
      S_HDR3 = 3'd4,
      S_LO   = 3'd5,
      S_HI   = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [C_CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]           lo_q, lo_d;
   logic [15:0]          pred_snap_q;
   logic [6:0]           idx_snap_q;
   logic [15:0]          hdr_pred_q;
   logic [6:0]           hdr_idx_q;
   logic                 in_ready_q, in_ready_d;
   logic                 overflow_q;

   logic [8:0]           fifo_mem_q [FIFO_DEPTH];
   logic [C_PTR_W-1:0]   wr_ptr_q;
   logic [C_PTR_W-1:0]   rd_ptr_q;
   logic [C_OCC_W-1:0]   occ_q, occ_d;

   logic                 w_accept;
   logic                 w_push;
   logic [7:0]           w_push_byte;
   logic                 w_push_last;
   logic                 w_pop;
   logic [C_CNT_W-1:0]   w_cnt_inc;
   logic [8:0]           w_head;

   assign w_accept  = inValid && in_ready_q;
   assign w_cnt_inc = cnt_q + C_CNT_ONE;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lo_d        = lo_q;
      w_push      = 1'b0;
      w_push_byte = 8'h00;
      w_push_last = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               lo_d    = inPCM;
               cnt_d   = C_CNT_ONE;
               state_d = S_HDR0;
            end
         end
         S_HDR0: begin
            w_push      = 1'b1;
            w_push_byte = hdr_pred_q[7:0];
            state_d     = S_HDR1;
         end
         S_HDR1: begin
            w_push      = 1'b1;
            w_push_byte = hdr_pred_q[15:8];
            state_d     = S_HDR2;
         end
         S_HDR2: begin
            w_push      = 1'b1;
            w_push_byte = {1'b0, hdr_idx_q};
            state_d     = S_HDR3;
         end
         S_HDR3: begin
            w_push      = 1'b1;
            w_push_byte = 8'h00;
            state_d     = S_HI;
         end
         S_LO: begin
            if (w_accept) begin
               lo_d    = inPCM;
               cnt_d   = w_cnt_inc;
               state_d = S_HI;
            end else if (flush && (cnt_q != '0)) begin
               // Previous byte already left unmarked; close with a pad byte.
               w_push      = 1'b1;
               w_push_byte = 8'h00;
               w_push_last = 1'b1;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end
         end
         S_HI: begin
            if (w_accept) begin
               w_push      = 1'b1;
               w_push_byte = {inPCM, lo_q};
               if (w_cnt_inc == C_CNT_FULL) begin
                  w_push_last = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d   = w_cnt_inc;
                  state_d = S_LO;
               end
            end else if (flush) begin
               w_push      = 1'b1;
               w_push_byte = {4'h0, lo_q};
               w_push_last = 1'b1;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign w_pop = outValid && outReady;
   assign occ_d = occ_q + {{C_PTR_W{1'b0}}, w_push} - {{C_PTR_W{1'b0}}, w_pop};

   // Ready looks one cycle ahead so a registered flag never lets a push hit a full FIFO.
   always_comb begin
      in_ready_d = 1'b0;
      if ((state_d == S_IDLE) || (state_d == S_LO) || (state_d == S_HI)) begin
         in_ready_d = (occ_d <= C_READY_MAX);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lo_q        <= 4'h0;
         pred_snap_q <= 16'h0000;
         idx_snap_q  <= 7'h00;
         hdr_pred_q  <= 16'h0000;
         hdr_idx_q   <= 7'h00;
         in_ready_q  <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lo_q       <= lo_d;
         in_ready_q <= in_ready_d;
         occ_q      <= occ_d;
         if (w_accept) begin
            pred_snap_q <= inPredictSamp;
            idx_snap_q  <= inStepIndex;
         end
         // Header carries the state in effect before the block's first code.
         if (w_accept && (state_q == S_IDLE)) begin
            hdr_pred_q <= pred_snap_q;
            hdr_idx_q  <= idx_snap_q;
         end
         if (inValid && !in_ready_q) begin
            overflow_q <= 1'b1;
         end
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         fifo_mem_q[wr_ptr_q] <= {w_push_last, w_push_byte};
      end
   end

   assign w_head   = fifo_mem_q[rd_ptr_q];
   assign outValid = (occ_q != '0);
   assign outByte  = outValid ? w_head[7:0] : 8'h00;
   assign outLast  = outValid ? w_head[8]   : 1'b0;
   assign inReady  = in_ready_q;
   assign overflow = overflow_q;

endmodule
`default_nettype wire
